// File: rtl/trisc2_control.sv
// TRISC2 fetch-decode-execute sequencer producing the c0..c14 control word.
// Optional single-step mode (step input, one instruction per pulse) is enabled by TRISC_SINGLE_STEP_EN.
module trisc2_control #(
  parameter int OPW = 4,
  parameter int CW  = 15
) (
  input  logic           clock,
  input  logic           clear_n,
  input  logic           startStop,
`ifdef TRISC_SINGLE_STEP_EN
  input  logic           step,
`endif
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic [CW-1:0]  ctrl,
  output logic [3:0]     state,
  output logic           instr_done,
  output logic           halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F1   = 4'd1,
    S_F2   = 4'd2,
    S_F3   = 4'd3,
    S_DEC  = 4'd4,
    S_E1   = 4'd5,
    S_E2   = 4'd6,
    S_E3   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP = OPW'(5);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(6);
  localparam logic [OPW-1:0] OP_OUT = OPW'(7);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  state_t         st;
  logic [OPW-1:0] op_q;
  logic           is_mem;
  logic           last;
  logic           go;
  logic           run_on;

  assign is_mem = (op_q >= OP_LDA) && (op_q <= OP_STA);
  assign last   = (st == S_E3) || ((st == S_E1) && !is_mem);

`ifdef TRISC_SINGLE_STEP_EN
  assign go     = startStop && step;
  assign run_on = 1'b0;
`else
  assign go     = startStop;
  assign run_on = startStop;
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      st   <= S_IDLE;
      op_q <= '0;
    end else begin
      case (st)
        S_IDLE: if (go) st <= S_F1;
        S_F1:   st <= S_F2;
        S_F2:   st <= S_F3;
        S_F3:   st <= S_DEC;
        S_DEC: begin
          op_q <= opcode;
          st   <= (opcode == OP_HLT) ? S_HALT : S_E1;
        end
        S_E1:   st <= is_mem ? S_E2 : (run_on ? S_F1 : S_IDLE);
        S_E2:   st <= S_E3;
        S_E3:   st <= run_on ? S_F1 : S_IDLE;
        S_HALT: st <= S_HALT;
        default: st <= S_IDLE;
      endcase
    end
  end

  // Control word decode; bit 6 is reserved and never set.
  always_comb begin
    ctrl = '0;
    case (st)
      S_F1: ctrl[2] = 1'b1;
      S_F2: begin
        ctrl[4] = 1'b1;
        ctrl[0] = 1'b1;
      end
      S_F3: ctrl[7] = 1'b1;
      S_E1: begin
        case (op_q)
          OP_LDA, OP_ADD, OP_SUB: ctrl[3] = 1'b1;
          OP_STA: begin
            ctrl[3]  = 1'b1;
            ctrl[12] = 1'b1;
          end
          OP_JMP: ctrl[1] = 1'b1;
          OP_JZ:  ctrl[1] = zero;
          OP_OUT: ctrl[13] = 1'b1;
          default: ctrl = '0;
        endcase
      end
      S_E2: begin
        ctrl[4] = 1'b1;
        ctrl[5] = (op_q == OP_STA);
      end
      S_E3: begin
        case (op_q)
          OP_LDA: ctrl[8] = 1'b1;
          OP_ADD: begin
            ctrl[9]  = 1'b1;
            ctrl[11] = 1'b1;
          end
          OP_SUB: begin
            ctrl[10] = 1'b1;
            ctrl[11] = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      S_HALT: ctrl[14] = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign state      = st;
  assign instr_done = last;
  assign halted     = (st == S_HALT);

endmodule
